problem1a_vector_checker: RTL and testbench

//  Self-checking stimulus/response engine for the problem1a combinational block.
//  - Drives A/B/C through all 8 input combinations.
//  - Waits a settle window, then samples X/Y/Z.
//  - Compares the sample against the golden function X=A, Y=B, Z=A|B.
//  - Reports error count and first failure.

---
 rtl/problem1a_vector_checker_if.sv | 12 +
 rtl/problem1a_vector_checker.sv | 115 +++++++++++
 tb/tb_problem1a_vector_checker.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/problem1a_vector_checker_if.sv
// Stimulus/response bus between the vector checker (master) and the block under check (slave).
interface problem1a_vector_checker_if;
  logic A_out;
  logic B_out;
  logic C_out;
  logic X_in;
  logic Y_in;
  logic Z_in;

  modport master (output A_out, B_out, C_out, input X_in, Y_in, Z_in);
  modport slave  (input A_out, B_out, C_out, output X_in, Y_in, Z_in);
endinterface

// File: rtl/problem1a_vector_checker.sv
// On-chip stimulus/response engine: walks {A,B,C} through all 8 vectors, waits a settle
// window per vector, and checks the response against X=A, Y=B, Z=A|B.
module problem1a_vector_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  problem1a_vector_checker_if.master       dut_bus,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic [ERR_W-1:0]                 err_count,
  output logic [2:0]                       first_fail_vec,
  output logic [2:0]                       first_fail_obs
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;
  localparam logic [2:0]       LAST_VEC    = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t           state;
  logic [2:0]       vec;
  logic [2:0]       abc;
  logic [CNT_W-1:0] cnt;

  logic [2:0]       sample_c;
  logic [2:0]       expect_c;
  logic             mismatch_c;
  logic [ERR_W-1:0] err_next_c;

  assign dut_bus.A_out = abc[2];
  assign dut_bus.B_out = abc[1];
  assign dut_bus.C_out = abc[0];

  // Golden response for the vector currently held on the bus; C does not affect it.
  assign sample_c   = {dut_bus.X_in, dut_bus.Y_in, dut_bus.Z_in};
  assign expect_c   = {vec[2], vec[1], vec[2] | vec[1]};
  assign mismatch_c = (sample_c != expect_c);
  assign err_next_c = (mismatch_c && (err_count != ERR_MAX)) ? err_count + ERR_W'(1)
                                                             : err_count;

  // Sequencer; reset discards any partial run.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      vec            <= 3'd0;
      abc            <= 3'd0;
      cnt            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_vec <= 3'd0;
      first_fail_obs <= 3'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            vec            <= 3'd0;
            abc            <= 3'd0;
            cnt            <= SETTLE_LOAD;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_vec <= 3'd0;
            first_fail_obs <= 3'd0;
            state          <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= S_COMPARE;
          end
        end

        S_COMPARE: begin
          err_count <= err_next_c;
          // Only the first failure of a run is kept.
          if (mismatch_c && (err_count == '0)) begin
            first_fail_vec <= vec;
            first_fail_obs <= sample_c;
          end
          if (vec != LAST_VEC) begin
            vec   <= vec + 3'(1);
            abc   <= vec + 3'(1);
            cnt   <= SETTLE_LOAD;
            state <= S_SETTLE;
          end else begin
            abc   <= 3'd0;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next_c == '0);
            state <= S_DONE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_problem1a_vector_checker.sv
// Bench for problem1a_vector_checker: a timeline model of a run checked every cycle on two
// instances (default and 2-bit error counter), plus literal expectations per scenario.
module tb_problem1a_vector_checker;

  localparam int unsigned S = 2;
  localparam int T = 8 * (S + 1);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  int   mode = 0;        // 0 golden, 1 Z stuck-at-0, 2 all outputs inverted

  problem1a_vector_checker_if bus0 ();
  problem1a_vector_checker_if bus1 ();

  logic       busy0, done0, pass0;
  logic [3:0] err0;
  logic [2:0] ffv0, ffo0;
  logic       busy1, done1, pass1;
  logic [1:0] err1;
  logic [2:0] ffv1, ffo1;

  problem1a_vector_checker #(.SETTLE_CYCLES(S), .ERR_W(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .dut_bus(bus0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_fail_vec(ffv0), .first_fail_obs(ffo0));

  problem1a_vector_checker #(.SETTLE_CYCLES(S), .ERR_W(2)) u_dut_w2 (
    .clk(clk), .reset_n(reset_n), .start(start), .dut_bus(bus1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail_vec(ffv1), .first_fail_obs(ffo1));

  always #5 clk = ~clk;

  // Response of the emulated block to vector v={A,B,C} in the given fault mode.
  function automatic logic [2:0] resp(input logic [2:0] v, input int m);
    logic [2:0] g;
    g = {v[2], v[1], v[2] | v[1]};
    case (m)
      1:       return {g[2:1], 1'b0};
      2:       return ~g;
      default: return g;
    endcase
  endfunction

  logic [2:0] abc0, abc1;
  assign abc0 = {bus0.A_out, bus0.B_out, bus0.C_out};
  assign abc1 = {bus1.A_out, bus1.B_out, bus1.C_out};

  always_comb begin
    {bus0.X_in, bus0.Y_in, bus0.Z_in} = resp(abc0, mode);
    {bus1.X_in, bus1.Y_in, bus1.Z_in} = resp(abc1, mode);
  end

  // Run timeline: edge index of the accepted start and the fault mode of that run.
  int cyc = 0;
  int t0 = 0;
  bit run_valid = 1'b0;
  int run_mode = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset_n) begin
      run_valid <= 1'b0;
    end else if (start && (!run_valid || (cyc - t0) >= T)) begin
      run_valid <= 1'b1;
      t0        <= cyc + 1;
      run_mode  <= mode;
    end
  end

  // Outputs k edges after the start edge: vectors finish every S+1 edges.
  task automatic model(input bit valid, input int k, input int m, input int emax,
                       output logic b, output logic d, output logic p, output int ec,
                       output logic [2:0] fv, output logic [2:0] fo, output logic [2:0] abc);
    int nc;
    int raw;
    logic [2:0] jv;
    logic [2:0] o;
    b = 1'b0; d = 1'b0; p = 1'b0; ec = 0; fv = 3'd0; fo = 3'd0; abc = 3'd0;
    if (valid) begin
      nc  = k / (S + 1);
      if (nc > 8) nc = 8;
      raw = 0;
      for (int j = 0; j < nc; j++) begin
        jv = 3'(j);
        o  = resp(jv, m);
        if (o != resp(jv, 0)) begin
          if (raw == 0) begin
            fv = jv;
            fo = o;
          end
          raw++;
        end
      end
      ec  = (raw > emax) ? emax : raw;
      b   = (k < T);
      d   = (k >= T);
      p   = d && (raw == 0);
      abc = b ? 3'(k / (S + 1)) : 3'd0;
    end
  endtask

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  bit chk_en = 1'b0;

  // Per-cycle comparison of both instances against the timeline model.
  always @(negedge clk) begin
    logic b, d, p;
    int ec;
    logic [2:0] fv, fo, abc;
    if (chk_en) begin
      model(run_valid, cyc - t0, run_mode, 15, b, d, p, ec, fv, fo, abc);
      check("busy", busy0, b);
      check("done", done0, d);
      check("pass", pass0, p);
      check("err_count", err0, ec);
      check("first_fail_vec", ffv0, fv);
      check("first_fail_obs", ffo0, fo);
      check("abc", abc0, abc);
      model(run_valid, cyc - t0, run_mode, 3, b, d, p, ec, fv, fo, abc);
      check("w2_busy", busy1, b);
      check("w2_done", done1, d);
      check("w2_pass", pass1, p);
      check("w2_err_count", err1, ec);
      check("w2_first_fail_vec", ffv1, fv);
      check("w2_first_fail_obs", ffo1, fo);
      check("w2_abc", abc1, abc);
    end
  end

  task automatic pulse_start(output int t);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = cyc;
  endtask

  task automatic wait_done(input int t_start, input string name);
    int lat;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (done0) begin
        lat = cyc - t_start;
        break;
      end
      @(negedge clk);
    end
    check(name, lat, 24);
  endtask

  initial begin
    int ts;
    int ts2;
    int guard;

    // Reset
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_done", done0, 0);
    check("reset_abc", abc0, 0);

    // 1: golden block
    mode = 0;
    pulse_start(ts);
    wait_done(ts, "t1_latency");
    check("t1_pass", pass0, 1);
    check("t1_err", err0, 0);
    check("t1_ffv", ffv0, 0);
    check("t1_ffo", ffo0, 0);
    repeat (3) @(negedge clk);

    // 2: Z stuck-at-0
    mode = 1;
    pulse_start(ts);
    wait_done(ts, "t2_latency");
    check("t2_err", err0, 6);
    check("t2_pass", pass0, 0);
    check("t2_ffv", ffv0, 3'b010);
    check("t2_ffo", ffo0, 3'b010);

    // 6: restart from DONE with a golden block
    mode = 0;
    pulse_start(ts);
    check("t6_cleared_err", err0, 0);
    check("t6_cleared_done", done0, 0);
    wait_done(ts, "t6_latency");
    check("t6_pass", pass0, 1);
    check("t6_err", err0, 0);

    // 3: every output inverted; the 2-bit counter saturates
    mode = 2;
    pulse_start(ts);
    wait_done(ts, "t3_latency");
    check("t3_w2_err", err1, 3);
    check("t3_w2_ffv", ffv1, 3'b000);
    check("t3_w2_ffo", ffo1, 3'b111);
    check("t3_w2_pass", pass1, 0);
    check("t3_err", err0, 8);

    // 5: start re-pulsed while busy is ignored
    mode = 0;
    pulse_start(ts);
    repeat (5) @(negedge clk);
    pulse_start(ts2);
    check("t5_still_busy", busy0, 1);
    wait_done(ts, "t5_latency");
    check("t5_pass", pass0, 1);

    // 4: one-cycle reset during vector 4
    pulse_start(ts);
    guard = 0;
    while (abc0 != 3'b100 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("t4_reached_vec4", abc0, 3'b100);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("t4_busy", busy0, 0);
    check("t4_abc", abc0, 0);
    check("t4_done", done0, 0);
    check("t4_err", err0, 0);
    repeat (4) @(negedge clk);
    check("t4_stays_idle", busy0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
